// File: rtl/game_cmd_ctrl.sv
// game_cmd_ctrl: debounces buttons and issues one legality-checked, acknowledged command at a time to gameFSM
module game_cmd_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       resetFSM_n,
   input  logic       btnStart,
   input  logic       btnPause,
   input  logic       btnReset,
   input  logic [2:0] state_in,
   output logic       startGame,
   output logic       pauseGame,
   output logic       reset,
   output logic       busy,
   output logic       rejected,
   output logic       timeout
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int TW = $clog2(ACK_TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
   // bit 0 start, bit 1 pause, bit 2 reset throughout
   logic [2:0] sync1, btn_s, level, level_d, ev, sel, ok, cmd, cmd_nxt;
   logic [DW-1:0] cnt [3];
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [2:0] issue_state, issue_nxt;
   logic legal, multi, rej_nxt, to_nxt;
   state_t state, state_nxt;
   assign ev = level & ~level_d;
   assign sel = ev[2] ? 3'b100 : ev[0] ? 3'b001 : ev[1] ? 3'b010 : 3'b000;
   assign ok = {state_in != 3'b011, state_in == 3'b001,
                state_in == 3'b000 || state_in == 3'b010 || state_in == 3'b011};
   assign legal = |(sel & ok);
   assign multi = |(ev & (ev - 3'd1));
   assign {reset, pauseGame, startGame} = cmd;
   // two-flop synchronizers and debounced-level history for edge detection
   always_ff @(posedge clk or negedge resetFSM_n)
      if (!resetFSM_n) begin
         sync1 <= '0;
         btn_s <= '0;
         level_d <= '0;
      end else begin
         sync1 <= {btnReset, btnPause, btnStart};
         btn_s <= sync1;
         level_d <= level;
      end
   // a level flips only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge resetFSM_n)
      if (!resetFSM_n) begin
         level <= '0;
         for (int k = 0; k < 3; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++)
            if (btn_s[k] == level[k]) cnt[k] <= '0;
            else if (cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
               cnt[k] <= '0;
               level[k] <= ~level[k];
            end else cnt[k] <= cnt[k] + 1'b1;
      end
   // command FSM state and registered outputs
   always_ff @(posedge clk or negedge resetFSM_n)
      if (!resetFSM_n) begin
         state <= IDLE;
         cmd <= '0;
         tcnt <= '0;
         issue_state <= '0;
         busy <= 1'b0;
         rejected <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         cmd <= cmd_nxt;
         tcnt <= tcnt_nxt;
         issue_state <= issue_nxt;
         busy <= state_nxt != IDLE;
         rejected <= rej_nxt;
         timeout <= to_nxt;
      end
   // next state: issue a legal winner, hold until state_in moves or the timer expires
   always_comb begin
      state_nxt = state;
      cmd_nxt = cmd;
      tcnt_nxt = tcnt;
      issue_nxt = issue_state;
      rej_nxt = |ev;
      to_nxt = 1'b0;
      case (state)
         IDLE: begin
            rej_nxt = |ev && (!legal || multi);
            if (legal) begin
               state_nxt = ISSUE;
               cmd_nxt = sel;
               tcnt_nxt = TW'(ACK_TIMEOUT - 1);
               issue_nxt = state_in;
            end
         end
         ISSUE:
            if (state_in != issue_state) begin
               cmd_nxt = '0;
               state_nxt = RELEASE;
            end else if (tcnt == '0) begin
               cmd_nxt = '0;
               to_nxt = 1'b1;
               state_nxt = RELEASE;
            end else tcnt_nxt = tcnt - 1'b1;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_game_cmd_ctrl.sv
// tb_game_cmd_ctrl: scoreboard bench for game_cmd_ctrl with DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8
module tb_game_cmd_ctrl;
   logic clk = 1'b0, resetFSM_n = 1'b0, btnStart = 1'b0, btnPause = 1'b0, btnReset = 1'b0;
   logic [2:0] state_in = 3'b000;
   logic startGame, pauseGame, reset, busy, rejected, timeout;
   logic [2:0] cmds, prev = 3'b000;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   int rise [3];
   logic [31:0] exp_q [$];

   game_cmd_ctrl #(.DEBOUNCE_CYCLES(4), .ACK_TIMEOUT(8)) dut (
      .clk(clk), .resetFSM_n(resetFSM_n), .btnStart(btnStart), .btnPause(btnPause),
      .btnReset(btnReset), .state_in(state_in), .startGame(startGame), .pauseGame(pauseGame),
      .reset(reset), .busy(busy), .rejected(rejected), .timeout(timeout));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign cmds = {reset, pauseGame, startGame};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // event word: kind (1 start,2 pause,3 reset,4 rejected,5 timeout), start cycle, width
   function automatic logic [31:0] ev(input int k, input int c, input int w);
      return {k[3:0], c[19:0], w[7:0]};
   endfunction

   task automatic emit(input logic [31:0] got);
      if (exp_q.size() == 0) chk("unexpected", got, 0);
      else chk("event", got, exp_q.pop_front());
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic settle();
      repeat (20) @(negedge clk);
      chk("q_empty", 32'(exp_q.size()), 0);
   endtask

   // monitor: commands reported on their falling edge, pulses when seen
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (cmds[k] && !prev[k]) rise[k] <= cyc;
         if (!cmds[k] && prev[k]) emit(ev(k + 1, rise[k], cyc - rise[k]));
      end
      if (rejected) emit(ev(4, cyc, 1));
      if (timeout) emit(ev(5, cyc, 1));
      prev <= cmds;
   end

   initial begin
      int r, q;
      repeat (3) @(negedge clk);
      chk("rst_out", 32'({startGame, pauseGame, reset, busy, rejected, timeout}), 0);
      resetFSM_n = 1'b1;
      repeat (5) @(negedge clk);
      // clean press, FSM acknowledges one cycle after startGame rises
      r = cyc; btnStart = 1'b1;
      exp_q.push_back(ev(1, r + 7, 2));
      at(r + 6); chk("busy_pre", 32'(busy), 0); chk("start_pre", 32'(startGame), 0);
      at(r + 7); chk("start_rise", 32'(startGame), 1); chk("busy_rise", 32'(busy), 1);
      at(r + 8); state_in = 3'b001;
      at(r + 9); chk("start_fall", 32'(startGame), 0); chk("busy_rel", 32'(busy), 1);
      at(r + 10); chk("busy_fall", 32'(busy), 0);
      btnStart = 1'b0; settle();
      // bounce then hold
      state_in = 3'b000;
      for (int k = 0; k < 6; k++) begin
         btnStart = ~btnStart;
         repeat (2) @(negedge clk);
      end
      r = cyc; btnStart = 1'b1;
      exp_q.push_back(ev(1, r + 7, 8));
      exp_q.push_back(ev(5, r + 15, 1));
      at(r + 7); chk("bounce_rise", 32'(startGame), 1);
      settle(); btnStart = 1'b0; settle();
      // pause is illegal in START
      r = cyc; btnPause = 1'b1;
      exp_q.push_back(ev(4, r + 7, 1));
      at(r + 7); chk("pause_none", 32'(pauseGame), 0); chk("pause_busy", 32'(busy), 0);
      btnPause = 1'b0; settle();
      // reset beats start on the same edge
      state_in = 3'b001;
      r = cyc; btnReset = 1'b1; btnStart = 1'b1;
      exp_q.push_back(ev(4, r + 7, 1));
      exp_q.push_back(ev(3, r + 7, 2));
      at(r + 7); chk("prio_reset", 32'(reset), 1); chk("prio_start", 32'(startGame), 0);
      chk("prio_rej", 32'(rejected), 1);
      at(r + 8); state_in = 3'b011;
      settle(); btnReset = 1'b0; btnStart = 1'b0; settle();
      // reset held in GAMEOVER without acknowledgement times out
      state_in = 3'b100;
      r = cyc; btnReset = 1'b1;
      exp_q.push_back(ev(3, r + 7, 8));
      exp_q.push_back(ev(5, r + 15, 1));
      at(r + 14); chk("to_hold", 32'(reset), 1);
      at(r + 15); chk("to_fall", 32'(reset), 0); chk("to_pulse", 32'(timeout), 1);
      chk("to_busy", 32'(busy), 1);
      at(r + 16); chk("to_idle", 32'(busy), 0); chk("to_once", 32'(timeout), 0);
      btnReset = 1'b0; settle();
      // asynchronous reset mid-command, button still held afterwards
      state_in = 3'b001;
      r = cyc; btnPause = 1'b1;
      exp_q.push_back(ev(2, r + 7, 2));
      at(r + 8); chk("rst_pre", 32'(pauseGame), 1);
      #2 resetFSM_n = 1'b0;
      #1 chk("async_clr", 32'({startGame, pauseGame, reset, busy, rejected, timeout}), 0);
      repeat (3) @(negedge clk);
      q = cyc;
      exp_q.push_back(ev(2, q + 7, 8));
      exp_q.push_back(ev(5, q + 15, 1));
      #2 resetFSM_n = 1'b1;
      at(q + 6); chk("rearm_pre", 32'(pauseGame), 0);
      at(q + 7); chk("rearm_rise", 32'(pauseGame), 1);
      settle(); btnPause = 1'b0; settle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
